// File: rtl/wb_uart_pkg.sv
// Shared definitions for the Wishbone UART channel mux: FSM encoding,
// local register offsets and the channel-index width helper.
package wb_uart_pkg;

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_ACCESS = 2'd1;
  localparam logic [1:0] ST_RESP   = 2'd2;

  localparam logic [1:0] REG_INT_PEND  = 2'd0;
  localparam logic [1:0] REG_INT_MASK  = 2'd1;
  localparam logic [1:0] REG_TO_STATUS = 2'd2;

  // One extra index value is reserved for the local register block.
  function automatic int unsigned idx_width(input int unsigned num_channels);
    return $clog2(num_channels + 1);
  endfunction

endpackage

// File: rtl/wb_uart_ack_timer.sv
// Ack-wait counter: cleared on request, counts while enabled, flags when
// LIMIT-1 is reached and holds there.
module wb_uart_ack_timer #(
  parameter int unsigned LIMIT = 255
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic clr_i,
  input  logic en_i,
  output logic expired_o
);

  localparam int unsigned CW = $clog2(LIMIT);

  logic [CW-1:0] count_q, count_d;

  assign expired_o = (count_q == CW'(LIMIT - 1));

  always_comb begin
    count_d = count_q;
    if (clr_i) begin
      count_d = '0;
    end else if (en_i && !expired_o) begin
      count_d = count_q + CW'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

endmodule

// File: rtl/wb_uart_channel_mux.sv
// Wishbone slave front-end for an N-channel UART cluster: channel decode,
// response mux, ack timeout, interrupt mask/status and aggregate irq.
module wb_uart_channel_mux
  import wb_uart_pkg::*;
#(
  parameter int unsigned NUM_CHANNELS = 4,
  parameter int unsigned DATA_WIDTH   = 32,
  parameter int unsigned ADDR_WIDTH   = 32,
  parameter int unsigned CHAN_SEL_LSB = 5,
  parameter int unsigned ACK_TIMEOUT  = 255
) (
  input  logic                               wb_clk_i,
  input  logic                               wb_rst_i,
  input  logic [ADDR_WIDTH-1:0]              wb_adr_i,
  input  logic [DATA_WIDTH-1:0]              wb_dat_i,
  output logic [DATA_WIDTH-1:0]              wb_dat_o,
  input  logic                               wb_we_i,
  input  logic                               wb_stb_i,
  input  logic                               wb_cyc_i,
  input  logic [DATA_WIDTH/8-1:0]            wb_sel_i,
  output logic                               wb_ack_o,
  output logic                               wb_err_o,
  output logic [NUM_CHANNELS-1:0]            ch_stb_o,
  output logic [CHAN_SEL_LSB-1:0]            ch_adr_o,
  output logic [DATA_WIDTH-1:0]              ch_dat_o,
  output logic                               ch_we_o,
  output logic [DATA_WIDTH/8-1:0]            ch_sel_o,
  input  logic [NUM_CHANNELS*DATA_WIDTH-1:0] ch_dat_i,
  input  logic [NUM_CHANNELS-1:0]            ch_ack_i,
  input  logic [NUM_CHANNELS-1:0]            ch_int_i,
  output logic                               irq_o
);

  localparam int unsigned     IDXW      = idx_width(NUM_CHANNELS);
  localparam int unsigned     SELW      = DATA_WIDTH / 8;
  localparam logic [IDXW-1:0] LOCAL_IDX = IDXW'(NUM_CHANNELS);

  logic [1:0]              state_q, state_d;
  logic [NUM_CHANNELS-1:0] ch_stb_q, ch_stb_d;
  logic [CHAN_SEL_LSB-1:0] ch_adr_q, ch_adr_d;
  logic [DATA_WIDTH-1:0]   ch_dat_q, ch_dat_d;
  logic                    ch_we_q, ch_we_d;
  logic [SELW-1:0]         ch_sel_q, ch_sel_d;
  logic [DATA_WIDTH-1:0]   wb_dat_q, wb_dat_d;
  logic                    ack_q, ack_d;
  logic                    err_q, err_d;
  logic [NUM_CHANNELS-1:0] int_mask_q, int_mask_d;
  logic [NUM_CHANNELS-1:0] to_status_q, to_status_d;
  logic                    irq_q, irq_d;

  logic [IDXW-1:0]         idx;
  logic                    ack_hit;
  logic                    expired;
  logic [DATA_WIDTH-1:0]   chan_rdata;
  logic [DATA_WIDTH-1:0]   local_rdata;
  logic [NUM_CHANNELS-1:0] byte_mask;
  logic [NUM_CHANNELS-1:0] to_set;
  logic [NUM_CHANNELS-1:0] to_clr;
  logic                    unused_inputs;

  assign idx           = wb_adr_i[CHAN_SEL_LSB +: IDXW];
  assign unused_inputs = ^{wb_adr_i, wb_dat_i, wb_sel_i};

  // ch_stb_q is one-hot on the selected channel, so it doubles as the
  // ack filter and read-data mux select without indexing by idx.
  assign ack_hit = |(ch_ack_i & ch_stb_q);

  always_comb begin
    chan_rdata = '0;
    for (int unsigned k = 0; k < NUM_CHANNELS; k++) begin
      if (ch_stb_q[k]) begin
        chan_rdata = chan_rdata | ch_dat_i[k*DATA_WIDTH +: DATA_WIDTH];
      end
    end
  end

  always_comb begin
    byte_mask = '0;
    for (int unsigned k = 0; k < NUM_CHANNELS; k++) begin
      byte_mask[k] = wb_sel_i[k/8];
    end
  end

  always_comb begin
    local_rdata = '0;
    case (wb_adr_i[3:2])
      REG_INT_PEND:  local_rdata[NUM_CHANNELS-1:0] = ch_int_i;
      REG_INT_MASK:  local_rdata[NUM_CHANNELS-1:0] = int_mask_q;
      REG_TO_STATUS: local_rdata[NUM_CHANNELS-1:0] = to_status_q;
      default:       local_rdata = '0;
    endcase
  end

  wb_uart_ack_timer #(
    .LIMIT(ACK_TIMEOUT)
  ) u_ack_timer (
    .clk_i    (wb_clk_i),
    .rst_i    (wb_rst_i),
    .clr_i    (state_q == ST_IDLE),
    .en_i     (state_q == ST_ACCESS),
    .expired_o(expired)
  );

  always_comb begin
    state_d    = state_q;
    ch_stb_d   = ch_stb_q;
    ch_adr_d   = ch_adr_q;
    ch_dat_d   = ch_dat_q;
    ch_we_d    = ch_we_q;
    ch_sel_d   = ch_sel_q;
    wb_dat_d   = '0;
    ack_d      = 1'b0;
    err_d      = 1'b0;
    int_mask_d = int_mask_q;
    to_set     = '0;
    to_clr     = '0;

    case (state_q)
      ST_IDLE: begin
        if (wb_cyc_i && wb_stb_i) begin
          ch_adr_d = wb_adr_i[CHAN_SEL_LSB-1:0];
          ch_dat_d = wb_dat_i;
          ch_we_d  = wb_we_i;
          ch_sel_d = wb_sel_i;
          if (idx < LOCAL_IDX) begin
            ch_stb_d = NUM_CHANNELS'(1) << idx;
            state_d  = ST_ACCESS;
          end else if (idx == LOCAL_IDX) begin
            if (wb_we_i) begin
              case (wb_adr_i[3:2])
                REG_INT_MASK:
                  int_mask_d = (int_mask_q & ~byte_mask) |
                               (wb_dat_i[NUM_CHANNELS-1:0] & byte_mask);
                REG_TO_STATUS: to_clr = wb_dat_i[NUM_CHANNELS-1:0] & byte_mask;
                default: ;
              endcase
            end else begin
              wb_dat_d = local_rdata;
            end
            ack_d   = 1'b1;
            state_d = ST_RESP;
          end else begin
            err_d   = 1'b1;
            state_d = ST_RESP;
          end
        end
      end
      ST_ACCESS: begin
        if (!wb_cyc_i) begin
          ch_stb_d = '0;
          state_d  = ST_IDLE;
        end else if (ack_hit) begin
          wb_dat_d = ch_we_q ? '0 : chan_rdata;
          ack_d    = 1'b1;
          ch_stb_d = '0;
          state_d  = ST_RESP;
        end else if (expired) begin
          to_set   = ch_stb_q;
          err_d    = 1'b1;
          ch_stb_d = '0;
          state_d  = ST_RESP;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    // Set wins over a simultaneous write-1-to-clear of the same bit.
    to_status_d = (to_status_q & ~to_clr) | to_set;
    irq_d       = (|(ch_int_i & int_mask_q)) | (|to_status_q);
  end

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      state_q     <= ST_IDLE;
      ch_stb_q    <= '0;
      ch_adr_q    <= '0;
      ch_dat_q    <= '0;
      ch_we_q     <= 1'b0;
      ch_sel_q    <= '0;
      wb_dat_q    <= '0;
      ack_q       <= 1'b0;
      err_q       <= 1'b0;
      int_mask_q  <= '0;
      to_status_q <= '0;
      irq_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      ch_stb_q    <= ch_stb_d;
      ch_adr_q    <= ch_adr_d;
      ch_dat_q    <= ch_dat_d;
      ch_we_q     <= ch_we_d;
      ch_sel_q    <= ch_sel_d;
      wb_dat_q    <= wb_dat_d;
      ack_q       <= ack_d;
      err_q       <= err_d;
      int_mask_q  <= int_mask_d;
      to_status_q <= to_status_d;
      irq_q       <= irq_d;
    end
  end

  assign wb_dat_o = wb_dat_q;
  assign wb_ack_o = ack_q;
  assign wb_err_o = err_q;
  assign ch_stb_o = ch_stb_q;
  assign ch_adr_o = ch_adr_q;
  assign ch_dat_o = ch_dat_q;
  assign ch_we_o  = ch_we_q;
  assign ch_sel_o = ch_sel_q;
  assign irq_o    = irq_q;

endmodule

// File: tb/tb_wb_uart_channel_mux.sv
// Randomised self-checking bench for wb_uart_channel_mux with a transaction-
// level model of the mask, timeout status and interrupt rules.
module tb_wb_uart_channel_mux;

  localparam int unsigned NC  = 4;
  localparam int unsigned DW  = 32;
  localparam int unsigned AW  = 32;
  localparam int unsigned LSB = 5;
  localparam int unsigned TO  = 8;

  logic              wb_clk_i = 1'b0;
  logic              wb_rst_i;
  logic [AW-1:0]     wb_adr_i;
  logic [DW-1:0]     wb_dat_i;
  logic [DW-1:0]     wb_dat_o;
  logic              wb_we_i;
  logic              wb_stb_i;
  logic              wb_cyc_i;
  logic [DW/8-1:0]   wb_sel_i;
  logic              wb_ack_o;
  logic              wb_err_o;
  logic [NC-1:0]     ch_stb_o;
  logic [LSB-1:0]    ch_adr_o;
  logic [DW-1:0]     ch_dat_o;
  logic              ch_we_o;
  logic [DW/8-1:0]   ch_sel_o;
  logic [NC*DW-1:0]  ch_dat_i;
  logic [NC-1:0]     ch_ack_i;
  logic [NC-1:0]     ch_int_i;
  logic              irq_o;

  int n_checks = 0;
  int n_bad    = 0;

  // Model state: what the register block should hold.
  logic [NC-1:0] m_mask;
  logic [NC-1:0] m_to;

  wb_uart_channel_mux #(
    .NUM_CHANNELS(NC),
    .DATA_WIDTH  (DW),
    .ADDR_WIDTH  (AW),
    .CHAN_SEL_LSB(LSB),
    .ACK_TIMEOUT (TO)
  ) dut (
    .wb_clk_i(wb_clk_i), .wb_rst_i(wb_rst_i), .wb_adr_i(wb_adr_i),
    .wb_dat_i(wb_dat_i), .wb_dat_o(wb_dat_o), .wb_we_i(wb_we_i),
    .wb_stb_i(wb_stb_i), .wb_cyc_i(wb_cyc_i), .wb_sel_i(wb_sel_i),
    .wb_ack_o(wb_ack_o), .wb_err_o(wb_err_o), .ch_stb_o(ch_stb_o),
    .ch_adr_o(ch_adr_o), .ch_dat_o(ch_dat_o), .ch_we_o(ch_we_o),
    .ch_sel_o(ch_sel_o), .ch_dat_i(ch_dat_i), .ch_ack_i(ch_ack_i),
    .ch_int_i(ch_int_i), .irq_o(irq_o)
  );

  always #5 wb_clk_i = ~wb_clk_i;

  initial begin
    #500000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge wb_clk_i);
    #1;
  endtask

  task automatic drive_req(input int unsigned idx, input logic [4:0] off, input logic we,
                           input logic [31:0] d, input logic [3:0] sel);
    logic [31:0] hi;
    hi       = $urandom;
    wb_adr_i = {hi[31:8], 8'h00} | (32'(idx) << LSB) | 32'(off);
    wb_dat_i = d;
    wb_we_i  = we;
    wb_sel_i = sel;
    wb_cyc_i = 1'b1;
    wb_stb_i = 1'b1;
  endtask

  task automatic end_req();
    wb_cyc_i = 1'b0;
    wb_stb_i = 1'b0;
    wb_we_i  = 1'b0;
  endtask

  task automatic check_idle_after(input string tag);
    tick();
    check_eq({tag, "_idle"}, {wb_ack_o, wb_err_o, ch_stb_o}, 32'h0);
    check_eq({tag, "_dat0"}, wb_dat_o, 32'h0);
  endtask

  // delay < 0 means the channel never acks.
  task automatic chan_access(input int unsigned ch, input logic we, input logic [31:0] wdata,
                             input logic [4:0] off, input int delay, input logic [31:0] rd);
    logic [3:0] hot;
    logic [3:0] sel;
    logic [3:0] noise;
    bit         accepted;
    int         r;
    hot      = 4'(1) << ch;
    sel      = 4'($urandom);
    accepted = (delay >= 0) && (delay < int'(TO));
    r        = accepted ? delay : int'(TO) - 1;
    for (int k = 0; k < int'(NC); k++) ch_dat_i[k*DW +: DW] = $urandom;
    ch_dat_i[ch*DW +: DW] = rd;
    drive_req(ch, off, we, wdata, sel);
    tick();
    check_eq("ch_stb", 32'(ch_stb_o), 32'(hot));
    check_eq("ch_dat", ch_dat_o, wdata);
    check_eq("ch_ctl", {ch_we_o, ch_sel_o, ch_adr_o}, {22'h0, we, sel, off});
    for (int c = 0; c <= r; c++) begin
      noise    = 4'($urandom);
      ch_ack_i = (noise & ~hot) | ((c == delay) ? hot : 4'h0);
      tick();
      if (c < r) check_eq("ch_busy", {wb_ack_o, wb_err_o, ch_stb_o}, {26'h0, 2'b00, hot});
    end
    ch_ack_i = '0;
    check_eq("ch_resp", {wb_ack_o, wb_err_o, ch_stb_o}, {26'h0, accepted, !accepted, 4'h0});
    check_eq("ch_rdat", wb_dat_o, (accepted && !we) ? rd : 32'h0);
    if (!accepted) m_to[ch] = 1'b1;
    end_req();
    check_idle_after("ch");
  endtask

  task automatic local_access(input logic [1:0] rg, input logic we, input logic [31:0] wdata,
                              input logic [3:0] sel);
    logic [31:0] exp;
    case (rg)
      2'd0:    exp = 32'(ch_int_i);
      2'd1:    exp = 32'(m_mask);
      2'd2:    exp = 32'(m_to);
      default: exp = 32'h0;
    endcase
    drive_req(NC, {1'b0, rg, 2'b00}, we, wdata, sel);
    tick();
    check_eq("loc_resp", {wb_ack_o, wb_err_o, ch_stb_o}, {26'h0, 6'b100000});
    check_eq("loc_rdat", wb_dat_o, we ? 32'h0 : exp);
    if (we) begin
      for (int k = 0; k < int'(NC); k++) begin
        if (rg == 2'd1 && sel[k/8]) m_mask[k] = wdata[k];
        if (rg == 2'd2 && sel[k/8] && wdata[k]) m_to[k] = 1'b0;
      end
    end
    end_req();
    check_idle_after("loc");
  endtask

  task automatic unmapped_access(input int unsigned idx);
    drive_req(idx, 5'($urandom), 1'($urandom), $urandom, 4'hF);
    tick();
    check_eq("unm_resp", {wb_ack_o, wb_err_o, ch_stb_o}, {26'h0, 6'b010000});
    end_req();
    check_idle_after("unm");
  endtask

  task automatic check_irq();
    tick();
    check_eq("irq", 32'(irq_o), 32'((|(ch_int_i & m_mask)) || (|m_to)));
  endtask

  initial begin
    int op;
    int dly;
    wb_rst_i = 1'b1;
    wb_adr_i = '0;
    wb_dat_i = '0;
    wb_we_i  = 1'b0;
    wb_stb_i = 1'b0;
    wb_cyc_i = 1'b0;
    wb_sel_i = '0;
    ch_dat_i = '0;
    ch_ack_i = '0;
    ch_int_i = '0;
    m_mask   = '0;
    m_to     = '0;
    tick();
    tick();
    check_eq("rst_ctl", {wb_ack_o, wb_err_o, irq_o, ch_we_o, ch_stb_o, ch_sel_o, ch_adr_o},
             32'h0);
    check_eq("rst_dat", wb_dat_o | ch_dat_o, 32'h0);
    wb_rst_i = 1'b0;
    tick();

    chan_access(2, 1'b1, 32'hA5, 5'h0, 3, 32'h0);
    chan_access(1, 1'b0, 32'h0, 5'h4, 2, 32'h5A);
    chan_access(0, 1'b0, 32'h0, 5'h8, 0, 32'h1234_5678);
    chan_access(3, 1'b0, 32'h0, 5'hC, -1, 32'h0);
    local_access(2'd2, 1'b0, 32'h0, 4'hF);
    check_irq();
    local_access(2'd2, 1'b1, 32'h8, 4'hF);
    check_irq();
    chan_access(2, 1'b0, 32'h0, 5'h0, int'(TO) - 1, 32'hCAFE);

    local_access(2'd1, 1'b1, 32'h1, 4'hF);
    ch_int_i = 4'b0011;
    check_irq();
    local_access(2'd1, 1'b1, 32'h0, 4'hF);
    check_irq();
    local_access(2'd0, 1'b0, 32'h0, 4'hF);
    local_access(2'd3, 1'b1, 32'hFFFF, 4'hF);
    local_access(2'd3, 1'b0, 32'h0, 4'hF);

    unmapped_access(7);
    unmapped_access(5);
    unmapped_access(6);

    local_access(2'd1, 1'b1, 32'hF, 4'hF);
    chan_access(1, 1'b0, 32'h0, 5'h0, -1, 32'h0);
    drive_req(0, 5'h10, 1'b1, 32'h77, 4'hF);
    tick();
    tick();
    wb_rst_i = 1'b1;
    tick();
    check_eq("rst_acc", {wb_ack_o, wb_err_o, irq_o, ch_stb_o}, 32'h0);
    wb_rst_i = 1'b0;
    end_req();
    m_mask = '0;
    m_to   = '0;
    tick();
    local_access(2'd1, 1'b0, 32'h0, 4'hF);
    local_access(2'd2, 1'b0, 32'h0, 4'hF);
    chan_access(0, 1'b0, 32'h0, 5'h10, 1, 32'hBEEF);
    check_irq();

    drive_req(1, 5'h4, 1'b0, 32'h0, 4'hF);
    tick();
    check_eq("abort_stb", 32'(ch_stb_o), 32'h2);
    tick();
    end_req();
    tick();
    check_eq("abort_out", {wb_ack_o, wb_err_o, ch_stb_o}, 32'h0);
    tick();
    check_eq("abort_hold", {wb_ack_o, wb_err_o, ch_stb_o}, 32'h0);
    local_access(2'd2, 1'b0, 32'h0, 4'hF);

    for (int it = 0; it < 60; it++) begin
      op = $urandom_range(0, 9);
      if (op <= 4) begin
        dly = $urandom_range(0, 10);
        if (dly == 10) dly = -1;
        chan_access($urandom_range(0, NC - 1), 1'($urandom), $urandom, 5'($urandom), dly,
                    $urandom);
      end else if (op <= 7) begin
        case ($urandom_range(0, 3))
          0: local_access(2'd0, 1'b0, 32'h0, 4'hF);
          1: local_access(2'd1, 1'($urandom), $urandom, 4'($urandom));
          2: local_access(2'd2, 1'($urandom), $urandom, 4'hF);
          default: local_access(2'd3, 1'($urandom), $urandom, 4'hF);
        endcase
      end else if (op == 8) begin
        unmapped_access($urandom_range(NC + 1, 7));
      end else begin
        ch_int_i = 4'($urandom);
      end
      check_irq();
    end

    $display("test done: total=%0d bad=%0d", n_checks, n_bad);
    $finish;
  end

endmodule
